// File: rtl/ps2_pkg.sv
// PS/2 frame layout constants and scan-code prefixes shared by the receiver
// and the downstream scan-code decoder.
package ps2_pkg;
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_START      = 0;
  localparam int PS2_PARITY     = 9;
  localparam int PS2_STOP       = 10;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Odd parity: the XOR over D0..D7 and the parity bit must be 1.
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[PS2_START] == 1'b0) && (f[PS2_STOP] == 1'b1) && ((^f[PS2_PARITY:1]) == 1'b1);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through circular FIFO with a sticky overflow flag.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             ready,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = rd_en && (count != '0);
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];
  assign ready   = (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (pop)
        overflow <= 1'b0;
      else if (wr_en && full)
        overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pad synchronisers, 11-bit frame deserialiser
// with validation and inactivity timeout, feeding a FWFT scan-code FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic s1, s2, s3;
  logic d1, d2;
  logic [3:0]  cnt;
  logic [9:0]  shreg;
  logic [IW-1:0] idle;

  logic                      fall;
  logic                      done;
  logic                      good;
  logic                      timeout;
  logic [PS2_FRAME_BITS-1:0] frame;

  assign fall    = s3 && !s2;
  // The bit arriving on this fall completes the frame view at index 10.
  assign frame   = {d2, shreg};
  assign done    = fall && (cnt == 4'd10);
  assign good    = ps2_frame_ok(frame);
  assign timeout = !fall && (cnt != 4'd0) && (idle == IW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      s3        <= 1'b1;
      d1        <= 1'b1;
      d2        <= 1'b1;
      cnt       <= 4'd0;
      shreg     <= '0;
      idle      <= '0;
      frame_err <= 1'b0;
    end else begin
      s1        <= ps2_clk;
      s2        <= s1;
      s3        <= s2;
      d1        <= ps2_data;
      d2        <= d1;
      frame_err <= (done && !good) || timeout;
      if (fall) begin
        shreg <= frame[PS2_FRAME_BITS-1:1];
        idle  <= '0;
        cnt   <= done ? 4'd0 : cnt + 4'd1;
      end else if (cnt == 4'd0) begin
        idle <= '0;
      end else if (timeout) begin
        cnt  <= 4'd0;
        idle <= '0;
      end else begin
        idle <= idle + IW'(1);
      end
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (done && good),
    .wr_data (frame[8:1]),
    .rd_en   (rd_en),
    .rd_data (data),
    .ready   (ready),
    .overflow(overflow)
  );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed PS/2 frames, a byte-queue reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_ps2_rx_fifo;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 200;
  localparam int HP      = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .data(data), .ready(ready), .overflow(overflow), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  bit err_seen = 1'b0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_err = 1'b0;
  int         ev_cyc[$];
  int         ev_kind[$];
  logic [7:0] ev_byte[$];

  logic [7:0] codes [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: kind 0 = good byte arrives, 1 = bad frame, 2 = timeout.
  initial begin
    bit pop;
    bit ev;
    int kind;
    logic [7:0] eb;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        ev_cyc.delete();
        ev_kind.delete();
        ev_byte.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
      end else begin
        pop  = rd_en && (mq.size() > 0);
        ev   = 1'b0;
        kind = 0;
        eb   = 8'h00;
        if (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
          ev = 1'b1;
          void'(ev_cyc.pop_front());
          kind = ev_kind.pop_front();
          eb   = ev_byte.pop_front();
        end
        if (pop) begin
          void'(mq.pop_front());
          m_ovf = 1'b0;
        end
        m_err = ev && (kind != 0);
        if (ev && kind == 0) begin
          if (mq.size() >= DEPTH) m_ovf = 1'b1;
          else mq.push_back(eb);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check1("ready", ready, mq.size() != 0);
        if (mq.size() != 0) check8("data", data, mq[0]);
        check1("overflow", overflow, m_ovf);
        check1("frame_err", frame_err, m_err);
        if (frame_err) err_seen = 1'b1;
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad);
    return {1'b1, (~(^b)) ^ bad, b, 1'b0};
  endfunction

  task automatic send(input logic [10:0] f, input int nbits, input bit pop_on_stop);
    int fc;
    bit good;
    fc = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      fc = cyc;
      if (i == 10) begin
        good = (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
        ev_cyc.push_back(fc + 3);
        ev_kind.push_back(good ? 0 : 1);
        ev_byte.push_back(f[8:1]);
      end
      if (i == 10 && pop_on_stop) begin
        repeat (2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        repeat (HP - 3) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    $display("frame %h bits=%0d pop=%0d sent", f, nbits, pop_on_stop);
    if (nbits > 0 && nbits < 11) begin
      ev_cyc.push_back(fc + 3 + TIMEOUT);
      ev_kind.push_back(2);
      ev_byte.push_back(8'h00);
    end
  endtask

  task automatic pop1();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    repeat (3) @(negedge clk);
    check1("rst_ready", ready, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    check1("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;

    send(mk(8'h1C, 1'b0), 11, 1'b0);
    check1("t1_ready", ready, 1'b1);
    check8("t1_data", data, 8'h1C);
    pop1();
    check1("t1_ready_after_pop", ready, 1'b0);

    err_seen = 1'b0;
    send(mk(8'h45, 1'b1), 11, 1'b0);
    check1("t2_err_seen", err_seen, 1'b1);
    check1("t2_ready", ready, 1'b0);

    for (int i = 0; i < 9; i++) send(mk(codes[i], 1'b0), 11, 1'b0);
    check1("t3_overflow", overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check8($sformatf("t3_pop%0d", i), data, codes[i]);
      pop1();
      if (i == 0) check1("t3_ovf_clear", overflow, 1'b0);
    end
    check1("t3_empty", ready, 1'b0);

    for (int i = 0; i < 8; i++) send(mk(codes[i], 1'b0), 11, 1'b0);
    send(mk(8'h4E, 1'b0), 11, 1'b1);
    check1("t4_overflow", overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? codes[i + 1] : 8'h4E;
      check8($sformatf("t4_pop%0d", i), data, exp_b);
      pop1();
    end
    check1("t4_empty", ready, 1'b0);

    err_seen = 1'b0;
    send(mk(8'h1C, 1'b0), 5, 1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    check1("t5_timeout_err", err_seen, 1'b1);
    check1("t5_ready", ready, 1'b0);
    send(mk(8'h1C, 1'b0), 11, 1'b0);
    check8("t5_data", data, 8'h1C);
    pop1();

    send(mk(8'h1B, 1'b0), 11, 1'b0);
    send(mk(8'h23, 1'b0), 11, 1'b0);
    send(mk(8'h2B, 1'b0), 6, 1'b0);
    check1("t6_ready_before", ready, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check1("t6_ready_rst", ready, 1'b0);
    check1("t6_overflow_rst", overflow, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(mk(8'h24, 1'b0), 11, 1'b0);
    check1("t6_ready", ready, 1'b1);
    check8("t6_data", data, 8'h24);
    pop1();
    check1("t6_empty", ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
